// File: rtl/ctrl_fu_pipe_if.sv
// Issue-side and result-side bundle of the pipelined control-transfer unit.
// The issuer drives the in_* fields; the unit drives the out_* fields.
interface ctrl_fu_pipe_if #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int IMM_W    = 16,
    parameter int CKPT     = 4,
    parameter int CKPT_LOG = 2,
    parameter int TAG_W    = 16
);
    logic                in_valid_i;
    logic [2:0]          in_op_i;
    logic [PC_W-1:0]     in_pc_i;
    logic [IMM_W-1:0]    in_imm_i;
    logic [DATA_W-1:0]   in_data1_i;
    logic [DATA_W-1:0]   in_data2_i;
    logic                in_pred_dir_i;
    logic [PC_W-1:0]     in_pred_tgt_i;
    logic [CKPT-1:0]     in_mask_i;
    logic [CKPT_LOG-1:0] in_smtid_i;
    logic [TAG_W-1:0]    in_tag_i;

    logic                out_valid_o;
    logic [CKPT-1:0]     out_mask_o;
    logic [CKPT_LOG-1:0] out_smtid_o;
    logic [TAG_W-1:0]    out_tag_o;
    logic [DATA_W-1:0]   out_result_o;
    logic [PC_W-1:0]     out_next_pc_o;
    logic                out_dir_o;
    logic                out_mispredict_o;

    modport master (
        output in_valid_i, in_op_i, in_pc_i, in_imm_i, in_data1_i,
               in_data2_i, in_pred_dir_i, in_pred_tgt_i, in_mask_i,
               in_smtid_i, in_tag_i,
        input  out_valid_o, out_mask_o, out_smtid_o, out_tag_o,
               out_result_o, out_next_pc_o, out_dir_o, out_mispredict_o
    );

    modport slave (
        input  in_valid_i, in_op_i, in_pc_i, in_imm_i, in_data1_i,
               in_data2_i, in_pred_dir_i, in_pred_tgt_i, in_mask_i,
               in_smtid_i, in_tag_i,
        output out_valid_o, out_mask_o, out_smtid_o, out_tag_o,
               out_result_o, out_next_pc_o, out_dir_o, out_mispredict_o
    );
endinterface

// File: rtl/ctrl_fu_pipe.sv
// Pipelined branch/jump resolution unit with per-stage branch-mask tracking,
// speculative kill, mask clear, global stall and a saturating mispredict count.
module ctrl_fu_pipe #(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 32,
    parameter int IMM_W      = 16,
    parameter int CKPT       = 4,
    parameter int CKPT_LOG   = 2,
    parameter int TAG_W      = 16,
    parameter int STAGES     = 2,
    parameter int INST_BYTES = 8,
    parameter int IMM_SHIFT  = 3,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_i,
    input  logic                ctrl_verified_i,
    input  logic                ctrl_mispredict_i,
    input  logic [CKPT_LOG-1:0] ctrl_smtid_i,
    ctrl_fu_pipe_if.slave       io,
    output logic [CNT_W-1:0]    mispredict_cnt_o
);

    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLTZ = 3'd2;
    localparam logic [2:0] OP_BGEZ = 3'd3;
    localparam logic [2:0] OP_J    = 3'd4;
    localparam logic [2:0] OP_JAL  = 3'd5;
    localparam logic [2:0] OP_JR   = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    typedef struct packed {
        logic                valid;
        logic [CKPT-1:0]     mask;
        logic [CKPT_LOG-1:0] smtid;
        logic [TAG_W-1:0]    tag;
        logic [DATA_W-1:0]   result;
        logic [PC_W-1:0]     next_pc;
        logic                dir;
        logic                mis;
    } pkt_t;

    logic            kill_en;
    logic            clr_en;
    logic [CKPT-1:0] clr_bit;

    assign kill_en = ctrl_verified_i & ctrl_mispredict_i;
    assign clr_en  = ctrl_verified_i & ~ctrl_mispredict_i;
    assign clr_bit = CKPT'(1) << ctrl_smtid_i;

    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] br;
    logic [PC_W-1:0] jmp;
    logic [PC_W-1:0] reg_tgt;
    logic [PC_W-1:0] tgt;
    logic            dir;
    logic            link;
    pkt_t            in_pkt;

    assign seq     = io.in_pc_i + PC_W'(INST_BYTES);
    assign br      = seq + (PC_W'($signed(io.in_imm_i)) << IMM_SHIFT);
    assign jmp     = PC_W'(io.in_imm_i) << IMM_SHIFT;
    assign reg_tgt = io.in_data1_i[PC_W-1:0];

    always_comb begin
        dir  = 1'b1;
        tgt  = br;
        link = 1'b0;
        unique case (io.in_op_i)
            OP_BEQ:  dir = (io.in_data1_i == io.in_data2_i);
            OP_BNE:  dir = (io.in_data1_i != io.in_data2_i);
            OP_BLTZ: dir = io.in_data1_i[DATA_W-1];
            OP_BGEZ: dir = ~io.in_data1_i[DATA_W-1];
            OP_J:    tgt = jmp;
            OP_JAL: begin
                tgt  = jmp;
                link = 1'b1;
            end
            OP_JR:   tgt = reg_tgt;
            OP_JALR: begin
                tgt  = reg_tgt;
                link = 1'b1;
            end
        endcase
    end

    always_comb begin
        in_pkt         = '0;
        in_pkt.valid   = io.in_valid_i;
        in_pkt.mask    = io.in_mask_i;
        in_pkt.smtid   = io.in_smtid_i;
        in_pkt.tag     = io.in_tag_i;
        in_pkt.result  = link ? DATA_W'(seq) : '0;
        in_pkt.next_pc = dir ? tgt : seq;
        in_pkt.dir     = dir;
        in_pkt.mis     = (dir != io.in_pred_dir_i) |
                         (dir & (tgt != io.in_pred_tgt_i));
    end

    // Stall holds data, but kill/clear still reach every held entry.
    for (genvar k = 1; k <= STAGES; k++) begin : g_st
        pkt_t prv;
        pkt_t nxt;
        pkt_t q;

        if (k == 1) begin : g_first
            assign prv = in_pkt;
        end else begin : g_rest
            assign prv = g_st[k-1].q;
        end

        always_comb begin
            nxt = stall_i ? q : prv;
            if (kill_en && nxt.mask[ctrl_smtid_i]) nxt.valid = 1'b0;
            if (clr_en) nxt.mask = nxt.mask & ~clr_bit;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) q <= '0;
            else        q <= nxt;
        end
    end

    pkt_t o;
    logic o_valid;

    assign o       = g_st[STAGES].q;
    assign o_valid = o.valid & ~(kill_en & o.mask[ctrl_smtid_i]);

    assign io.out_valid_o      = o_valid;
    assign io.out_mask_o       = o.mask;
    assign io.out_smtid_o      = o.smtid;
    assign io.out_tag_o        = o.tag;
    assign io.out_result_o     = o.result;
    assign io.out_next_pc_o    = o.next_pc;
    assign io.out_dir_o        = o.dir;
    assign io.out_mispredict_o = o.mis;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispredict_cnt_o <= '0;
        end else if (o_valid && o.mis && !stall_i &&
                     mispredict_cnt_o != '1) begin
            mispredict_cnt_o <= mispredict_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ctrl_fu_pipe.sv
// Bench for ctrl_fu_pipe: directed vector table, hand-written kill/stall/
// saturation/reset sequences and random traffic against a reference model.
module tb_ctrl_fu_pipe;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic ver;
    logic misp;
    logic [1:0] sid;
    logic [CW-1:0] cnt;

    int errors = 0;
    int checks = 0;

    ctrl_fu_pipe_if bus ();

    ctrl_fu_pipe #(.CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall),
        .ctrl_verified_i  (ver),
        .ctrl_mispredict_i(misp),
        .ctrl_smtid_i     (sid),
        .io               (bus.slave),
        .mispredict_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v;
        bit [3:0]  mask;
        bit [1:0]  smtid;
        bit [15:0] tag;
        bit [31:0] res;
        bit [31:0] npc;
        bit        dir;
        bit        mis;
    } ent_t;

    typedef struct {
        bit [2:0]  op;
        bit [31:0] pc;
        bit [15:0] imm;
        bit [31:0] d1;
        bit [31:0] d2;
        bit        pd;
        bit [31:0] pt;
        bit [31:0] res;
        bit [31:0] npc;
        bit        dir;
        bit        mis;
    } vec_t;

    ent_t pipe[2];
    int   mcnt;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic ent_t ref_exec(bit [2:0] op, bit [31:0] pc,
                                      bit [15:0] imm, bit [31:0] a,
                                      bit [31:0] b, bit pd, bit [31:0] pt);
        ent_t e;
        bit [31:0] seq, tgt;
        bit d;
        e = '{default: 0};
        seq = pc + 32'd8;
        d = 1'b1;
        tgt = seq + ({{16{imm[15]}}, imm} * 32'd8);
        case (op)
            3'd0: d = (a == b);
            3'd1: d = (a != b);
            3'd2: d = ($signed(a) < 0);
            3'd3: d = ($signed(a) >= 0);
            3'd4, 3'd5: tgt = {16'd0, imm} * 32'd8;
            default: tgt = a;
        endcase
        e.dir = d;
        e.npc = d ? tgt : seq;
        e.res = (op == 3'd5 || op == 3'd7) ? seq : 32'd0;
        e.mis = (d != pd) || (d && tgt != pt);
        return e;
    endfunction

    function automatic ent_t upd(ent_t e);
        ent_t r = e;
        if (ver && misp && r.mask[sid]) r.v = 1'b0;
        if (ver && !misp) r.mask[sid] = 1'b0;
        return r;
    endfunction

    function automatic bit exp_valid();
        return pipe[1].v && !(ver && misp && pipe[1].mask[sid]);
    endfunction

    task automatic model_reset();
        pipe[0] = '{default: 0};
        pipe[1] = '{default: 0};
        mcnt = 0;
    endtask

    task automatic check_outputs();
        #1;
        chk("out_valid", bus.out_valid_o, exp_valid());
        if (exp_valid()) begin
            chk("out_mask", bus.out_mask_o, pipe[1].mask);
            chk("out_smtid", bus.out_smtid_o, pipe[1].smtid);
            chk("out_tag", bus.out_tag_o, pipe[1].tag);
            chk("out_result", bus.out_result_o, pipe[1].res);
            chk("out_next_pc", bus.out_next_pc_o, pipe[1].npc);
            chk("out_dir", bus.out_dir_o, pipe[1].dir);
            chk("out_mis", bus.out_mispredict_o, pipe[1].mis);
        end
        chk("cnt", cnt, mcnt);
    endtask

    task automatic model_step();
        ent_t n;
        if (exp_valid() && pipe[1].mis && !stall && mcnt < 15) mcnt++;
        if (stall) begin
            pipe[1] = upd(pipe[1]);
            pipe[0] = upd(pipe[0]);
        end else begin
            n = ref_exec(bus.in_op_i, bus.in_pc_i, bus.in_imm_i,
                         bus.in_data1_i, bus.in_data2_i,
                         bus.in_pred_dir_i, bus.in_pred_tgt_i);
            n.v = bus.in_valid_i;
            n.mask = bus.in_mask_i;
            n.smtid = bus.in_smtid_i;
            n.tag = bus.in_tag_i;
            pipe[1] = upd(pipe[0]);
            pipe[0] = upd(n);
        end
    endtask

    task automatic tick();
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic issue(bit [2:0] op, bit [31:0] pc, bit [15:0] imm,
                         bit [31:0] d1, bit [31:0] d2, bit pd,
                         bit [31:0] pt, bit [3:0] mask, bit [1:0] s,
                         bit [15:0] tag);
        bus.in_valid_i = 1'b1;
        bus.in_op_i = op;
        bus.in_pc_i = pc;
        bus.in_imm_i = imm;
        bus.in_data1_i = d1;
        bus.in_data2_i = d2;
        bus.in_pred_dir_i = pd;
        bus.in_pred_tgt_i = pt;
        bus.in_mask_i = mask;
        bus.in_smtid_i = s;
        bus.in_tag_i = tag;
    endtask

    task automatic idle();
        bus.in_valid_i = 1'b0;
    endtask

    vec_t tv[10];

    initial begin
        tv[0] = '{3'd0, 32'h100, 16'h0004, 32'd5, 32'd5, 1'b1, 32'h128,
                  32'h0, 32'h128, 1'b1, 1'b0};
        tv[1] = '{3'd1, 32'h200, 16'h0004, 32'd7, 32'd7, 1'b1, 32'h228,
                  32'h0, 32'h208, 1'b0, 1'b1};
        tv[2] = '{3'd7, 32'h300, 16'h0000, 32'h4000, 32'd0, 1'b1, 32'h4000,
                  32'h308, 32'h4000, 1'b1, 1'b0};
        tv[3] = '{3'd7, 32'h300, 16'h0000, 32'h4000, 32'd0, 1'b1, 32'h4008,
                  32'h308, 32'h4000, 1'b1, 1'b1};
        tv[4] = '{3'd2, 32'h400, 16'hFFFE, 32'h80000000, 32'd0, 1'b0, 32'h0,
                  32'h0, 32'h3F8, 1'b1, 1'b1};
        tv[5] = '{3'd3, 32'h500, 16'h0002, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h0,
                  32'h0, 32'h508, 1'b0, 1'b0};
        tv[6] = '{3'd4, 32'h600, 16'h8000, 32'd0, 32'd0, 1'b1, 32'h40000,
                  32'h0, 32'h40000, 1'b1, 1'b0};
        tv[7] = '{3'd5, 32'h700, 16'h0010, 32'd0, 32'd0, 1'b1, 32'h80,
                  32'h708, 32'h80, 1'b1, 1'b0};
        tv[8] = '{3'd6, 32'h800, 16'h0000, 32'h1234, 32'd0, 1'b0, 32'h0,
                  32'h0, 32'h1234, 1'b1, 1'b1};
        tv[9] = '{3'd0, 32'hFFFFFFF8, 16'h0000, 32'd1, 32'd1, 1'b1, 32'h0,
                  32'h0, 32'h0, 1'b1, 1'b0};

        reset = 1'b0;
        stall = 1'b0;
        ver = 1'b0;
        misp = 1'b0;
        sid = 2'd0;
        issue(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        model_reset();
        #12;
        chk("reset_valid", bus.out_valid_o, 1'b0);
        chk("reset_cnt", cnt, 0);
        chk("reset_npc", bus.out_next_pc_o, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            issue(tv[i].op, tv[i].pc, tv[i].imm, tv[i].d1, tv[i].d2,
                  tv[i].pd, tv[i].pt, 4'b0, 2'd0, 16'(i));
            tick();
            idle();
            tick();
            #1;
            chk($sformatf("vec%0d_valid", i), bus.out_valid_o, 1'b1);
            chk($sformatf("vec%0d_npc", i), bus.out_next_pc_o, tv[i].npc);
            chk($sformatf("vec%0d_dir", i), bus.out_dir_o, tv[i].dir);
            chk($sformatf("vec%0d_res", i), bus.out_result_o, tv[i].res);
            chk($sformatf("vec%0d_mis", i), bus.out_mispredict_o, tv[i].mis);
            chk($sformatf("vec%0d_tag", i), bus.out_tag_o, i);
            tick();
        end
        chk("table_cnt", cnt, 4);

        // kill in stage 1
        issue(3'd0, 32'h100, 16'd4, 5, 5, 1, 32'h128, 4'b0010, 2'd3, 16'hA1);
        tick();
        idle();
        ver = 1'b1;
        misp = 1'b1;
        sid = 2'd1;
        tick();
        ver = 1'b0;
        #1;
        chk("kill_s1_valid", bus.out_valid_o, 1'b0);
        tick();

        // mask clear in stage 1
        issue(3'd0, 32'h100, 16'd4, 5, 5, 1, 32'h128, 4'b0010, 2'd3, 16'hA2);
        tick();
        idle();
        ver = 1'b1;
        misp = 1'b0;
        tick();
        ver = 1'b0;
        #1;
        chk("clr_s1_valid", bus.out_valid_o, 1'b1);
        chk("clr_s1_mask", bus.out_mask_o, 4'b0000);
        chk("clr_s1_tag", bus.out_tag_o, 16'hA2);
        tick();

        // stall with a mispredict at the output
        issue(3'd1, 32'h200, 16'd4, 7, 7, 1, 32'h228, 4'b0001, 2'd0, 16'hB1);
        tick();
        idle();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_valid", bus.out_valid_o, 1'b1);
            chk("stall_cnt", cnt, 4);
            tick();
        end
        stall = 1'b0;
        tick();
        chk("stall_release_cnt", cnt, 5);

        // kill while stalled drops out_valid in the same cycle
        issue(3'd1, 32'h200, 16'd4, 7, 7, 1, 32'h228, 4'b0100, 2'd0, 16'hB2);
        tick();
        idle();
        tick();
        stall = 1'b1;
        tick();
        ver = 1'b1;
        misp = 1'b1;
        sid = 2'd2;
        #1;
        chk("stall_kill_now", bus.out_valid_o, 1'b0);
        tick();
        ver = 1'b0;
        misp = 1'b0;
        #1;
        chk("stall_kill_after", bus.out_valid_o, 1'b0);
        stall = 1'b0;
        tick();
        tick();
        chk("stall_kill_cnt", cnt, 5);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit [2:0] op;
            bit [31:0] pc, d1, d2, pt;
            bit [15:0] imm;
            bit pd;
            ent_t g;
            op = 3'($urandom_range(0, 7));
            pc = $urandom & 32'hFFFFFFF8;
            imm = 16'($urandom);
            d1 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            d2 = $urandom_range(0, 1) ? d1 : $urandom;
            pd = 1'($urandom_range(0, 1));
            g = ref_exec(op, pc, imm, d1, d2, 1'b1, 32'h0);
            pt = $urandom_range(0, 2) != 0 ? g.npc : $urandom;
            stall = ($urandom_range(0, 4) == 0);
            if (!stall && $urandom_range(0, 3) != 0)
                issue(op, pc, imm, d1, d2, pd, pt, 4'($urandom),
                      2'($urandom), 16'($urandom));
            else
                idle();
            ver = ($urandom_range(0, 2) == 0);
            misp = 1'($urandom_range(0, 1));
            sid = 2'($urandom);
            tick();
        end
        stall = 1'b0;
        ver = 1'b0;
        idle();
        tick();
        tick();

        // saturation
        for (int i = 0; i < 20; i++) begin
            issue(3'd6, 32'h900, 16'd0, 32'h500, 0, 1'b0, 32'h0, 4'b0,
                  2'd0, 16'(i));
            tick();
        end
        idle();
        tick();
        tick();
        tick();
        chk("sat_cnt", cnt, 4'hF);

        // asynchronous reset mid-stream
        issue(3'd6, 32'h900, 16'd0, 32'h500, 0, 1'b0, 32'h0, 4'b0, 2'd0, 16'h77);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("mid_reset_valid", bus.out_valid_o, 1'b0);
        chk("mid_reset_cnt", cnt, 0);
        chk("mid_reset_tag", bus.out_tag_o, 0);
        chk("mid_reset_npc", bus.out_next_pc_o, 0);
        model_reset();
        idle();
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
